pong_renderer: RTL and testbench

//  Pixel-colour stage directly downstream of the game-logic block. Consumes sprite

---
 rtl/pong_pkg.sv | 98 +++++++++
 rtl/pong_renderer_if.sv | 35 +++
 rtl/seg7_glyph.sv | 36 +++
 rtl/pong_renderer.sv | 153 +++++++++++++++
 tb/tb_pong_renderer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared geometry, colours, reset positions and 7-seg helpers for pong
package pong_pkg;

    localparam int H_VIDEO    = 640;
    localparam int V_VIDEO    = 480;
    localparam int SQ_W       = 16;
    localparam int PDL_W      = 12;
    localparam int PDL_H      = 96;

    localparam int SQ_X_RST   = 320;
    localparam int SQ_Y_RST   = 240;
    localparam int PDL1_X_RST = 24;
    localparam int PDL1_Y_RST = 191;
    localparam int PDL2_X_RST = 603;
    localparam int PDL2_Y_RST = 191;

    localparam logic [11:0] FG_RGB    = 12'hFFF;
    localparam logic [11:0] NET_RGB   = 12'h888;
    localparam logic [11:0] SCORE_RGB = 12'hAAA;

    localparam int NET_X_LO   = 318;
    localparam int NET_X_HI   = 321;

    localparam int DIG_W      = 16;
    localparam int DIG_H      = 28;
    localparam int DIG_STROKE = 4;
    localparam int DIG_MID    = (DIG_H - DIG_STROKE) / 2;
    localparam int DIG_Y      = 16;
    localparam int P1_TENS_X  = 256;
    localparam int P1_UNITS_X = 280;
    localparam int P2_TENS_X  = 344;
    localparam int P2_UNITS_X = 368;

    typedef struct packed {
        logic [9:0] sq_x;
        logic [9:0] sq_y;
        logic [9:0] pdl1_x;
        logic [9:0] pdl1_y;
        logic [9:0] pdl2_x;
        logic [9:0] pdl2_y;
        logic       sq_shown;
    } sprite_snap_t;

    localparam sprite_snap_t SNAP_RST = '{
        sq_x:     10'(SQ_X_RST),
        sq_y:     10'(SQ_Y_RST),
        pdl1_x:   10'(PDL1_X_RST),
        pdl1_y:   10'(PDL1_Y_RST),
        pdl2_x:   10'(PDL2_X_RST),
        pdl2_y:   10'(PDL2_Y_RST),
        sq_shown: 1'b0
    };

    // Segment mask bit order {g,f,e,d,c,b,a}; codes above 9 are dark.
    function automatic logic [6:0] seg_mask(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Widened to 11 bits so base+len near the top of the 10-bit range cannot wrap.
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] base,
                                     input logic [10:0] len);
        logic [10:0] p11;
        logic [10:0] b11;
        p11 = {1'b0, p};
        b11 = {1'b0, base};
        return (p11 >= b11) && (p11 < (b11 + len));
    endfunction

    function automatic logic [3:0] tens_of(input logic [3:0] s);
        return (s >= 4'd10) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [3:0] units_of(input logic [3:0] s);
        return (s >= 4'd10) ? (s - 4'd10) : s;
    endfunction

    function automatic logic [9:0] digit_x(input int idx);
        case (idx)
            0:       return 10'(P1_TENS_X);
            1:       return 10'(P1_UNITS_X);
            2:       return 10'(P2_TENS_X);
            default: return 10'(P2_UNITS_X);
        endcase
    endfunction

endpackage

// File: rtl/pong_renderer_if.sv
// rtl/pong_renderer_if.sv - pixel timing, game state and VGA output bundle for the renderer
interface pong_renderer_if;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_start;
    logic [9:0]  sq_xpos;
    logic [9:0]  sq_ypos;
    logic [9:0]  pdl1_xpos;
    logic [9:0]  pdl1_ypos;
    logic [9:0]  pdl2_xpos;
    logic [9:0]  pdl2_ypos;
    logic        sq_shown;
    logic [3:0]  score_p1;
    logic [3:0]  score_p2;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        output px_x, px_y, video_on, hsync_in, vsync_in, frame_start,
        output sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
        output sq_shown, score_p1, score_p2,
        input  rgb, hsync_out, vsync_out
    );

    modport slave (
        input  px_x, px_y, video_on, hsync_in, vsync_in, frame_start,
        input  sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
        input  sq_shown, score_p1, score_p2,
        output rgb, hsync_out, vsync_out
    );
endinterface

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational 7-segment glyph: digit plus in-box offset to lit pixel
module seg7_glyph
    import pong_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] dx,
    input  logic [4:0] dy,
    output logic       lit
);
    logic [6:0] m;
    logic       left;
    logic       right;
    logic       top;
    logic       mid;
    logic       bot;
    logic       upper;
    logic       lower;

    assign m     = seg_mask(digit);
    assign left  = dx < 4'(DIG_STROKE);
    assign right = dx >= 4'(DIG_W - DIG_STROKE);
    assign top   = dy < 5'(DIG_STROKE);
    assign mid   = (dy >= 5'(DIG_MID)) && (dy < 5'(DIG_MID + DIG_STROKE));
    assign bot   = (dy >= 5'(DIG_H - DIG_STROKE)) && (dy < 5'(DIG_H));
    // Upper and lower verticals share the middle bar's rows so the strokes join.
    assign upper = dy < 5'(DIG_MID + DIG_STROKE);
    assign lower = (dy >= 5'(DIG_MID)) && (dy < 5'(DIG_H));

    assign lit = (m[0] & top)
               | (m[1] & right & upper)
               | (m[2] & right & lower)
               | (m[3] & bot)
               | (m[4] & left & lower)
               | (m[5] & left & upper)
               | (m[6] & mid);
endmodule

// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - per-frame snapshotted sprite/score renderer, fixed 2-cycle pixel pipeline
// Score digits are drawn only when PONG_SCORE_EN is defined.
module pong_renderer
    import pong_pkg::*;
(
    input  logic            clk_0,
    input  logic            rst,
    pong_renderer_if.slave  bus
);
    sprite_snap_t snap;
    sprite_snap_t snap_d;

    logic sq_hit;
    logic pdl_hit;
    logic net_px;
    logic score_px;

    logic s1_valid;
    logic s1_video_on;
    logic s1_hs;
    logic s1_vs;
    logic s1_sq;
    logic s1_pdl;
    logic s1_score;
    logic s1_net;

    logic [11:0] rgb_q;
    logic        hs_q;
    logic        vs_q;

    assign snap_d = '{
        sq_x:     bus.sq_xpos,
        sq_y:     bus.sq_ypos,
        pdl1_x:   bus.pdl1_xpos,
        pdl1_y:   bus.pdl1_ypos,
        pdl2_x:   bus.pdl2_xpos,
        pdl2_y:   bus.pdl2_ypos,
        sq_shown: bus.sq_shown
    };

    // Game state only moves at frame boundaries so a frame never tears.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            snap <= SNAP_RST;
        end else if (bus.frame_start) begin
            snap <= snap_d;
        end
    end

`ifdef PONG_SCORE_EN
    logic [3:0] score_p1_q;
    logic [3:0] score_p2_q;
    logic [3:0] dig_val [4];
    logic [3:0] box_on;
    logic [3:0] glyph_lit;
    logic [3:0] dig_show;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            score_p1_q <= 4'd0;
            score_p2_q <= 4'd0;
        end else if (bus.frame_start) begin
            score_p1_q <= bus.score_p1;
            score_p2_q <= bus.score_p2;
        end
    end

    assign dig_val[0] = tens_of(score_p1_q);
    assign dig_val[1] = units_of(score_p1_q);
    assign dig_val[2] = tens_of(score_p2_q);
    assign dig_val[3] = units_of(score_p2_q);

    for (genvar i = 0; i < 4; i++) begin : g_digit
        localparam logic [9:0] BX = digit_x(i);

        assign box_on[i] = in_span(bus.px_x, BX, 11'(DIG_W))
                        && in_span(bus.px_y, 10'(DIG_Y), 11'(DIG_H));
        // Tens digits (even slots) are blanked when zero; units always show.
        assign dig_show[i] = ((i % 2) == 1) || (dig_val[i] != 4'd0);

        seg7_glyph u_glyph (
            .digit (dig_val[i]),
            .dx    (4'(bus.px_x - BX)),
            .dy    (5'(bus.px_y - 10'(DIG_Y))),
            .lit   (glyph_lit[i])
        );
    end

    assign score_px = |(box_on & glyph_lit & dig_show);
`else
    logic unused_score;
    assign unused_score = ^{bus.score_p1, bus.score_p2};
    assign score_px     = 1'b0;
`endif

    assign sq_hit  = snap.sq_shown
                  && in_span(bus.px_x, snap.sq_x, 11'(SQ_W))
                  && in_span(bus.px_y, snap.sq_y, 11'(SQ_W));
    assign pdl_hit = (in_span(bus.px_x, snap.pdl1_x, 11'(PDL_W))
                   && in_span(bus.px_y, snap.pdl1_y, 11'(PDL_H)))
                  || (in_span(bus.px_x, snap.pdl2_x, 11'(PDL_W))
                   && in_span(bus.px_y, snap.pdl2_y, 11'(PDL_H)));
    assign net_px  = (bus.px_x >= 10'(NET_X_LO)) && (bus.px_x <= 10'(NET_X_HI))
                  && !bus.px_y[4];

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_video_on <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_sq       <= 1'b0;
            s1_pdl      <= 1'b0;
            s1_score    <= 1'b0;
            s1_net      <= 1'b0;
        end else begin
            s1_valid    <= 1'b1;
            s1_video_on <= bus.video_on;
            s1_hs       <= bus.hsync_in;
            s1_vs       <= bus.vsync_in;
            s1_sq       <= sq_hit;
            s1_pdl      <= pdl_hit;
            s1_score    <= score_px;
            s1_net      <= net_px;
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            hs_q <= s1_hs;
            vs_q <= s1_vs;
            if (!s1_valid || !s1_video_on) begin
                rgb_q <= 12'h000;
            end else if (s1_sq || s1_pdl) begin
                rgb_q <= FG_RGB;
            end else if (s1_score) begin
                rgb_q <= SCORE_RGB;
            end else if (s1_net) begin
                rgb_q <= NET_RGB;
            end else begin
                rgb_q <= 12'h000;
            end
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.hsync_out = hs_q;
    assign bus.vsync_out = vs_q;
endmodule

// File: tb/tb_pong_renderer.sv
// tb/tb_pong_renderer.sv - randomized bench against a rectangle/glyph-level pong renderer model
module tb_pong_renderer;
    logic clk_0 = 1'b0;
    logic rst   = 1'b0;
    always #20 clk_0 = ~clk_0;

    pong_renderer_if bus();

    pong_renderer dut (
        .clk_0 (clk_0),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Pending input values, applied inside step() right after a falling edge.
    int n_sq_x = 320, n_sq_y = 240, n_p1_x = 24, n_p1_y = 191, n_p2_x = 603, n_p2_y = 191;
    int n_s1 = 0, n_s2 = 0;
    bit n_shown = 1'b0;
    bit n_rst   = 1'b0;

    // Model of what the renderer currently has latched for the frame.
    int m_sq_x, m_sq_y, m_p1_x, m_p1_y, m_p2_x, m_p2_y, m_s1, m_s2;
    bit m_shown;

    logic [13:0] pipe [2];
    string glyph [10];

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sq_x = 320; m_sq_y = 240; m_p1_x = 24; m_p1_y = 191;
        m_p2_x = 603; m_p2_y = 191; m_s1 = 0; m_s2 = 0; m_shown = 1'b0;
    endtask

    function automatic bit inside_rect(int px, int py, int x, int y, int w, int h);
        return (px >= x) && (px < x + w) && (py >= y) && (py < y + h);
    endfunction

    function automatic bit seg_rect(byte s, int dx, int dy);
        case (s)
            "a":     return dy < 4;
            "b":     return dx >= 12 && dy < 16;
            "c":     return dx >= 12 && dy >= 12;
            "d":     return dy >= 24;
            "e":     return dx < 4 && dy >= 12;
            "f":     return dx < 4 && dy < 16;
            "g":     return dy >= 12 && dy < 16;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit digit_pixel(int d, int dx, int dy);
        for (int k = 0; k < glyph[d].len(); k++) begin
            if (seg_rect(glyph[d][k], dx, dy)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit score_pixel(int px, int py);
        int sc, tx, ux;
        for (int p = 0; p < 2; p++) begin
            sc = (p == 0) ? m_s1 : m_s2;
            tx = (p == 0) ? 256 : 344;
            ux = (p == 0) ? 280 : 368;
            if (sc / 10 != 0 && inside_rect(px, py, tx, 16, 16, 28)
                && digit_pixel(sc / 10, px - tx, py - 16)) return 1'b1;
            if (inside_rect(px, py, ux, 16, 16, 28)
                && digit_pixel(sc % 10, px - ux, py - 16)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [13:0] model_out();
        logic [11:0] c;
        int px, py;
        px = int'(bus.px_x);
        py = int'(bus.px_y);
        if (!bus.video_on) c = 12'h000;
        else if (m_shown && inside_rect(px, py, m_sq_x, m_sq_y, 16, 16)) c = 12'hFFF;
        else if (inside_rect(px, py, m_p1_x, m_p1_y, 12, 96)
              || inside_rect(px, py, m_p2_x, m_p2_y, 12, 96)) c = 12'hFFF;
`ifdef PONG_SCORE_EN
        else if (score_pixel(px, py)) c = 12'hAAA;
`endif
        else if (px >= 318 && px <= 321 && (py / 16) % 2 == 0) c = 12'h888;
        else c = 12'h000;
        return {c, bus.hsync_in, bus.vsync_in};
    endfunction

    task automatic step(input int x, input int y, input bit von, input bit hs, input bit vs,
                        input bit fs);
        @(negedge clk_0);
        check_eq("rgb", bus.rgb, pipe[1][13:2]);
        check_eq("hsync_out", 12'(bus.hsync_out), 12'(pipe[1][1]));
        check_eq("vsync_out", 12'(bus.vsync_out), 12'(pipe[1][0]));
        pipe[1] = pipe[0];
        rst = n_rst;
        bus.px_x = 10'(x);       bus.px_y = 10'(y);
        bus.video_on = von;      bus.hsync_in = hs;   bus.vsync_in = vs;
        bus.frame_start = fs;
        bus.sq_xpos = 10'(n_sq_x);   bus.sq_ypos = 10'(n_sq_y);
        bus.pdl1_xpos = 10'(n_p1_x); bus.pdl1_ypos = 10'(n_p1_y);
        bus.pdl2_xpos = 10'(n_p2_x); bus.pdl2_ypos = 10'(n_p2_y);
        bus.sq_shown = n_shown;
        bus.score_p1 = 4'(n_s1);     bus.score_p2 = 4'(n_s2);
        if (!rst) begin
            pipe[0] = {12'h000, 2'b11};
            model_reset();
        end else begin
            pipe[0] = model_out();
            if (fs) begin
                m_sq_x = n_sq_x; m_sq_y = n_sq_y; m_p1_x = n_p1_x; m_p1_y = n_p1_y;
                m_p2_x = n_p2_x; m_p2_y = n_p2_y; m_s1 = n_s1; m_s2 = n_s2;
                m_shown = n_shown;
            end
        end
    endtask

    task automatic idle(input bit fs);
        step(0, 0, 1'b0, 1'b1, 1'b1, fs);
    endtask

    task automatic expect_px(input string tag, input int x, input int y, input logic [11:0] exp);
        step(x, y, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check_eq(tag, bus.rgb, exp);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        glyph = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                  "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
        pipe[0] = {12'h000, 2'b11};
        pipe[1] = {12'h000, 2'b11};
        model_reset();
        bus.px_x = '0; bus.px_y = '0; bus.video_on = 1'b0;
        bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.frame_start = 1'b0;
        bus.sq_xpos = '0; bus.sq_ypos = '0; bus.pdl1_xpos = '0; bus.pdl1_ypos = '0;
        bus.pdl2_xpos = '0; bus.pdl2_ypos = '0; bus.sq_shown = 1'b0;
        bus.score_p1 = '0; bus.score_p2 = '0;

        repeat (3) idle(1'b0);
        check_eq("reset_rgb", bus.rgb, 12'h000);
        check_eq("reset_hsync", 12'(bus.hsync_out), 12'h001);
        n_rst = 1'b1;
        idle(1'b0);

        // Square latched at (100,100), edges on both sides.
        n_sq_x = 100; n_sq_y = 100; n_shown = 1'b1;
        idle(1'b1);
        expect_px("t2_sq_in", 100, 100, 12'hFFF);
        expect_px("t2_sq_corner", 115, 115, 12'hFFF);
        expect_px("t2_sq_right", 116, 100, 12'h000);
        expect_px("t2_sq_left", 99, 100, 12'h000);

        // Mid-frame move is invisible until the next frame_start.
        n_sq_x = 200;
        expect_px("t3_old_pos", 100, 100, 12'hFFF);
        expect_px("t3_new_pos", 200, 100, 12'h000);
        idle(1'b1);
        expect_px("t3_new_latched", 200, 100, 12'hFFF);
        expect_px("t3_old_gone", 100, 100, 12'h000);

        n_shown = 1'b0;
        idle(1'b1);
        expect_px("t4_sq_hidden", 200, 100, 12'h000);
        expect_px("t4_pdl1_in", 35, 286, 12'hFFF);
        expect_px("t4_pdl1_right", 36, 286, 12'h000);
        expect_px("t4_pdl1_below", 35, 287, 12'h000);
        expect_px("t4_pdl2_in", 614, 191, 12'hFFF);
        expect_px("t4_pdl2_left", 602, 191, 12'h000);

        n_s1 = 10;
        idle(1'b1);
`ifdef PONG_SCORE_EN
        expect_px("t5_tens1_b", 269, 18, 12'hAAA);
        expect_px("t5_tens1_a_off", 257, 17, 12'h000);
        expect_px("t5_units0_a", 281, 17, 12'hAAA);
        expect_px("t5_units0_g_off", 288, 30, 12'h000);
`else
        expect_px("t5_tens_off", 269, 18, 12'h000);
        expect_px("t5_units_off", 281, 17, 12'h000);
`endif
        n_s1 = 3;
        idle(1'b1);
`ifdef PONG_SCORE_EN
        expect_px("t5_tens_blank", 269, 18, 12'h000);
        expect_px("t5_units3_a", 281, 17, 12'hAAA);
        expect_px("t5_units3_f_off", 281, 20, 12'h000);
`else
        expect_px("t5_units3_off", 281, 17, 12'h000);
`endif

        // Asynchronous reset mid-line while the outputs are non-idle.
        n_shown = 1'b1;
        repeat (3) step(30, 200, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk_0);
        #5;
        rst = 1'b0;
        n_rst = 1'b0;
        #1;
        check_eq("t1_async_rgb", bus.rgb, 12'h000);
        check_eq("t1_async_hsync", 12'(bus.hsync_out), 12'h001);
        check_eq("t1_async_vsync", 12'(bus.vsync_out), 12'h001);
        pipe[0] = {12'h000, 2'b11};
        pipe[1] = {12'h000, 2'b11};
        model_reset();
        repeat (3) step(30, 200, 1'b1, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        expect_px("t1_hold_sq", 200, 100, 12'h000);
        expect_px("t1_hold_pdl", 30, 200, 12'hFFF);
        idle(1'b1);
        expect_px("t1_next_frame", 200, 100, 12'hFFF);

        // Blanking overrides sprites; syncs follow the input two cycles late.
        step(30, 200, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check_eq("t6_blank", bus.rgb, 12'h000);
        for (int i = 0; i < 24; i++) begin
            step(30, 200, 1'b1, 1'($urandom()), 1'($urandom()), 1'b0);
        end

        for (int c = 0; c < 4000; c++) begin
            int x, y;
            bit fs, von;
            if ($urandom_range(0, 24) == 0) begin
                n_sq_x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                                     : int'($urandom_range(0, 639));
                n_sq_y = int'($urandom_range(0, 479));
                n_p1_x = int'($urandom_range(0, 100));
                n_p1_y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(960, 1023))
                                                     : int'($urandom_range(0, 400));
                n_p2_x = int'($urandom_range(500, 1023));
                n_p2_y = int'($urandom_range(0, 400));
                n_shown = ($urandom_range(0, 3) != 0);
                n_s1 = int'($urandom_range(0, 15));
                n_s2 = int'($urandom_range(0, 15));
            end
            case ($urandom_range(0, 3))
                0: begin x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479)); end
                1: begin
                    x = m_sq_x + int'($urandom_range(0, 19)) - 2;
                    y = m_sq_y + int'($urandom_range(0, 19)) - 2;
                end
                2: begin
                    x = (($urandom_range(0, 1) == 0) ? m_p1_x : m_p2_x)
                        + int'($urandom_range(0, 15)) - 2;
                    y = m_p1_y + int'($urandom_range(0, 99)) - 2;
                end
                default: begin
                    x = int'($urandom_range(250, 390));
                    y = int'($urandom_range(10, 50));
                end
            endcase
            fs  = ($urandom_range(0, 39) == 0);
            von = ($urandom_range(0, 9) != 0);
            step(x & 1023, y & 1023, von, 1'($urandom()), 1'($urandom()), fs);
        end
        idle(1'b0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
